axi_tdd_sync_gen_mc: RTL and testbench

//  Multi-source TDD sync generator. Merges N external sync inputs (per-input CDC, edge select, mask),
//  a programmable-period internal trigger and a software strobe into one stretched sync_out pulse.

---
 rtl/axi_tdd_sync_gen_mc.sv | 218 +++++++++++++++++++++
 tb/tb_axi_tdd_sync_gen_mc.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tdd_sync_gen_mc.sv
// axi_tdd_sync_gen_mc
// Multi-source TDD sync generator. Merges masked, edge-selected external sync
// inputs, a programmable-period internal trigger and a software strobe into a
// single registered, stretched sync pulse with one-shot arming and
// drop-while-busy behaviour.
//
// Optional feature macro: AXI_TDD_SYNC_STATS_EN
//   When defined, adds sync_pulse_cnt / sync_drop_cnt saturating statistics
//   counters. When undefined, those ports and their logic are absent.

`timescale 1ns/1ps

module axi_tdd_sync_gen_mc #(
  parameter int         NUM_EXT_SYNC      = 1,
  parameter logic [7:0] SYNC_EXTERNAL_CDC = 8'h01,
  parameter int         SYNC_COUNT_WIDTH  = 64,
  parameter int         PULSE_WIDTH_BITS  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_EXT_SYNC-1:0]     sync_in,
  output logic                        sync_out,
  output logic                        sync_busy,
  input  logic                        tdd_enable,
  input  logic [NUM_EXT_SYNC-1:0]     tdd_sync_ext_mask,
  input  logic [NUM_EXT_SYNC-1:0]     tdd_sync_ext_edge,
  input  logic                        tdd_sync_int,
  input  logic                        tdd_sync_soft,
  input  logic                        tdd_sync_oneshot,
  input  logic [SYNC_COUNT_WIDTH-1:0] asy_tdd_sync_period,
  input  logic [PULSE_WIDTH_BITS-1:0] asy_tdd_sync_width
`ifdef AXI_TDD_SYNC_STATS_EN
  ,
  output logic [31:0]                 sync_pulse_cnt,
  output logic [31:0]                 sync_drop_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_PULSE    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [SYNC_COUNT_WIDTH-1:0] period_q;
  logic [SYNC_COUNT_WIDTH-1:0] cnt;
  logic [PULSE_WIDTH_BITS-1:0] width_q;
  logic [PULSE_WIDTH_BITS-1:0] width_eff;
  logic [PULSE_WIDTH_BITS-1:0] wcnt;
  logic [PULSE_WIDTH_BITS-1:0] wcnt_next;
  logic [NUM_EXT_SYNC-1:0]     ev_ext;
  logic                        cnt_last;
  logic                        ev_int;
  logic                        ev;

  // Quasi-static settings follow the register map while disabled and are
  // frozen for the whole enable session so a running period never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= '0;
      width_q  <= '0;
    end else if (state == ST_DISABLED) begin
      period_q <= asy_tdd_sync_period;
      width_q  <= asy_tdd_sync_width;
    end
  end

  // A programmed width of zero still produces a one-cycle pulse.
  assign width_eff = (width_q == '0) ? PULSE_WIDTH_BITS'(1) : width_q;

  // Per-input detector: optional two-flop synchronizer, a sample flop and a
  // previous-sample flop, with the transition selected by the edge setting.
  for (genvar i = 0; i < NUM_EXT_SYNC; i++) begin : g_ext
    logic samp_q;
    logic prev_q;

    if (SYNC_EXTERNAL_CDC[i]) begin : g_cdc
      logic [1:0] cdc_ff;

      // Two metastability flops ahead of the sample flop for asynchronous inputs.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cdc_ff <= 2'b00;
          samp_q <= 1'b0;
        end else begin
          cdc_ff <= {cdc_ff[0], sync_in[i]};
          samp_q <= cdc_ff[1];
        end
      end
    end else begin : g_nocdc
      // Inputs already in the clk domain are sampled directly.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          samp_q <= 1'b0;
        end else begin
          samp_q <= sync_in[i];
        end
      end
    end

    // Previous sample used to spot the level transition.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prev_q <= 1'b0;
      end else begin
        prev_q <= samp_q;
      end
    end

    assign ev_ext[i] = tdd_sync_ext_mask[i] &
                       (tdd_sync_ext_edge[i] ? (~samp_q & prev_q) : (samp_q & ~prev_q));
  end

  // The internal trigger fires on the last count of each period; a zero
  // period never fires because the counter is pinned at zero.
  assign cnt_last = (cnt == (period_q - SYNC_COUNT_WIDTH'(1)));
  assign ev_int   = tdd_sync_int & (state != ST_DISABLED) & (period_q != '0) & cnt_last;

  // Period counter runs in every enabled state, including during a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state == ST_DISABLED) || (period_q == '0) || cnt_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + SYNC_COUNT_WIDTH'(1);
    end
  end

  assign ev = (|ev_ext) | ev_int | tdd_sync_soft;

  // Next-state logic: enable drop always wins, pulses are never extended
  // or retriggered, and one-shot sessions park in DONE after the first pulse.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    if (!tdd_enable) begin
      state_next = ST_DISABLED;
    end else begin
      case (state)
        ST_DISABLED: state_next = ST_ARMED;
        ST_ARMED: begin
          if (ev) begin
            state_next = ST_PULSE;
            wcnt_next  = width_eff - PULSE_WIDTH_BITS'(1);
          end
        end
        ST_PULSE: begin
          if (wcnt == '0) begin
            state_next = tdd_sync_oneshot ? ST_DONE : ST_ARMED;
          end else begin
            wcnt_next = wcnt - PULSE_WIDTH_BITS'(1);
          end
        end
        ST_DONE:  state_next = ST_DONE;
        default:  state_next = ST_DISABLED;
      endcase
    end
  end

  // State, width counter and the registered pulse output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_DISABLED;
      wcnt     <= '0;
      sync_out <= 1'b0;
    end else begin
      state    <= state_next;
      wcnt     <= wcnt_next;
      sync_out <= (state_next == ST_PULSE);
    end
  end

  assign sync_busy = sync_out;

`ifdef AXI_TDD_SYNC_STATS_EN
  logic enable_d;
  logic enable_rise;
  logic pulse_start;
  logic pulse_drop;

  assign enable_rise = tdd_enable & ~enable_d;
  assign pulse_start = tdd_enable & ev & (state == ST_ARMED);
  assign pulse_drop  = tdd_enable & ev & ((state == ST_PULSE) || (state == ST_DONE));

  // Delayed enable so each new session starts its statistics from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_d <= 1'b0;
    end else begin
      enable_d <= tdd_enable;
    end
  end

  // Saturating counters for accepted pulses and events lost while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_pulse_cnt <= '0;
      sync_drop_cnt  <= '0;
    end else if (enable_rise) begin
      sync_pulse_cnt <= '0;
      sync_drop_cnt  <= '0;
    end else begin
      if (pulse_start && (sync_pulse_cnt != 32'hFFFF_FFFF)) begin
        sync_pulse_cnt <= sync_pulse_cnt + 32'd1;
      end
      if (pulse_drop && (sync_drop_cnt != 32'hFFFF_FFFF)) begin
        sync_drop_cnt <= sync_drop_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_tdd_sync_gen_mc.sv
// Testbench for axi_tdd_sync_gen_mc: randomized sessions checked every cycle
// against a time-based reference model (absolute cycle numbers for session
// start and pulse end, arithmetic period phase, sampled input history).

`timescale 1ns/1ps

module tb_axi_tdd_sync_gen_mc;

  localparam int         NEXT   = 2;
  localparam logic [7:0] TB_CDC = 8'h02;

  logic              clk;
  logic              rst;
  logic [NEXT-1:0]   sync_in;
  logic              sync_out;
  logic              sync_busy;
  logic              tdd_enable;
  logic [NEXT-1:0]   tdd_sync_ext_mask;
  logic [NEXT-1:0]   tdd_sync_ext_edge;
  logic              tdd_sync_int;
  logic              tdd_sync_soft;
  logic              tdd_sync_oneshot;
  logic [15:0]       asy_tdd_sync_period;
  logic [7:0]        asy_tdd_sync_width;
`ifdef AXI_TDD_SYNC_STATS_EN
  logic [31:0]       sync_pulse_cnt;
  logic [31:0]       sync_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [NEXT-1:0] st_sync = '0;
  logic [NEXT-1:0] st_mask = '0;
  logic [NEXT-1:0] st_edge = '0;
  logic            st_en = 1'b0;
  logic            st_soft = 1'b0;
  logic            st_int = 1'b0;
  logic            st_oneshot = 1'b0;
  logic [15:0]     st_period = '0;
  logic [7:0]      st_width = '0;

  bit              sess_on;
  bit              spent;
  bit              exp_out;
  bit              en_d_m;
  int              sess_start;
  int              pulse_end;
  int              p_lat;
  int              w_lat;
  int              pulse_cnt_m;
  int              drop_cnt_m;
  logic [NEXT-1:0] hist [0:4];

  axi_tdd_sync_gen_mc #(
    .NUM_EXT_SYNC      (NEXT),
    .SYNC_EXTERNAL_CDC (TB_CDC),
    .SYNC_COUNT_WIDTH  (16),
    .PULSE_WIDTH_BITS  (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sync_in             (sync_in),
    .sync_out            (sync_out),
    .sync_busy           (sync_busy),
    .tdd_enable          (tdd_enable),
    .tdd_sync_ext_mask   (tdd_sync_ext_mask),
    .tdd_sync_ext_edge   (tdd_sync_ext_edge),
    .tdd_sync_int        (tdd_sync_int),
    .tdd_sync_soft       (tdd_sync_soft),
    .tdd_sync_oneshot    (tdd_sync_oneshot),
    .asy_tdd_sync_period (asy_tdd_sync_period),
    .asy_tdd_sync_width  (asy_tdd_sync_width)
`ifdef AXI_TDD_SYNC_STATS_EN
    ,
    .sync_pulse_cnt      (sync_pulse_cnt),
    .sync_drop_cnt       (sync_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Clear the reference model to its post-reset view.
  task automatic modelReset();
    sess_on     = 1'b0;
    spent       = 1'b0;
    exp_out     = 1'b0;
    en_d_m      = 1'b0;
    sess_start  = 0;
    pulse_end   = -1;
    p_lat       = 0;
    w_lat       = 1;
    pulse_cnt_m = 0;
    drop_cnt_m  = 0;
    for (int j = 0; j < 5; j++) hist[j] = '0;
  endtask

  // One clock cycle: check outputs at the negedge, drive staged inputs,
  // then advance the model to predict the next cycle.
  task automatic applyStimulus();
    bit   ev_any;
    bit   ev_i;
    bit   ev;
    bit   busy;
    int   d;
    logic a;
    logic b;
    @(negedge clk);
    checkOutput("sync_out", 32'(sync_out), 32'(exp_out));
    checkOutput("sync_busy", 32'(sync_busy), 32'(exp_out));
`ifdef AXI_TDD_SYNC_STATS_EN
    checkOutput("pulse_cnt", sync_pulse_cnt, 32'(pulse_cnt_m));
    checkOutput("drop_cnt", sync_drop_cnt, 32'(drop_cnt_m));
`endif
    sync_in             = st_sync;
    tdd_enable          = st_en;
    tdd_sync_soft       = st_soft;
    tdd_sync_int        = st_int;
    tdd_sync_oneshot    = st_oneshot;
    tdd_sync_ext_mask   = st_mask;
    tdd_sync_ext_edge   = st_edge;
    asy_tdd_sync_period = st_period;
    asy_tdd_sync_width  = st_width;

    for (int j = 4; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = sync_in;
    ev_any = 1'b0;
    for (int i = 0; i < NEXT; i++) begin
      d = TB_CDC[i] ? 2 : 0;
      a = hist[1+d][i];
      b = hist[2+d][i];
      if (tdd_sync_ext_mask[i] && (tdd_sync_ext_edge[i] ? (!a && b) : (a && !b))) ev_any = 1'b1;
    end
    ev_i = sess_on && tdd_sync_int && (p_lat != 0) && (((cyc - sess_start) % p_lat) == p_lat - 1);
    ev   = ev_any || ev_i || tdd_sync_soft;
    busy = sess_on && (cyc <= pulse_end);

    if (tdd_enable && !en_d_m) begin
      pulse_cnt_m = 0;
      drop_cnt_m  = 0;
    end else if (sess_on && tdd_enable && ev) begin
      if (!busy && !spent) pulse_cnt_m++;
      else drop_cnt_m++;
    end
    en_d_m = tdd_enable;

    if (!sess_on) begin
      p_lat = int'(asy_tdd_sync_period);
      w_lat = (asy_tdd_sync_width == 8'd0) ? 1 : int'(asy_tdd_sync_width);
      if (tdd_enable) begin
        sess_on    = 1'b1;
        sess_start = cyc + 1;
        spent      = 1'b0;
        pulse_end  = -1;
      end
    end else if (!tdd_enable) begin
      sess_on   = 1'b0;
      pulse_end = -1;
    end else if (ev && !busy && !spent) begin
      pulse_end = cyc + w_lat;
      if (tdd_sync_oneshot) spent = 1'b1;
    end
    exp_out = sess_on && ((cyc + 1) <= pulse_end);
    cyc++;
  endtask

  // Asynchronous reset: outputs must clear immediately, not at the next edge.
  task automatic doReset();
    @(negedge clk);
    rst           = 1'b1;
    st_sync       = '0;
    st_en         = 1'b0;
    st_soft       = 1'b0;
    sync_in       = '0;
    tdd_enable    = 1'b0;
    tdd_sync_soft = 1'b0;
    #1;
    checkOutput("rst_sync_out", 32'(sync_out), 32'd0);
    checkOutput("rst_sync_busy", 32'(sync_busy), 32'd0);
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One enable session with random soft strobes, input toggles and
  // optional short enable drops; p_mid >= 0 changes the period mid-session.
  task automatic runSession(input int p, input int w, input bit i_en, input bit os,
                            input logic [NEXT-1:0] msk, input logic [NEXT-1:0] edg,
                            input int ncyc, input int soft_pct, input int tog_pct,
                            input int dis_pct, input int p_mid);
    st_period  = 16'(p);
    st_width   = 8'(w);
    st_int     = i_en;
    st_oneshot = os;
    st_mask    = msk;
    st_edge    = edg;
    st_en      = 1'b0;
    st_soft    = 1'b0;
    repeat (2) applyStimulus();
    for (int c = 0; c < ncyc; c++) begin
      if ((p_mid >= 0) && (c == ncyc / 2)) st_period = 16'(p_mid);
      st_en   = ($urandom_range(0, 99) >= dis_pct);
      st_soft = ($urandom_range(0, 99) < soft_pct);
      for (int b = 0; b < NEXT; b++) begin
        if ($urandom_range(0, 99) < tog_pct) st_sync[b] = ~st_sync[b];
      end
      applyStimulus();
    end
    st_en   = 1'b0;
    st_soft = 1'b0;
    repeat (2) applyStimulus();
  endtask

  initial begin
    rst                 = 1'b1;
    sync_in             = '0;
    tdd_enable          = 1'b0;
    tdd_sync_ext_mask   = '0;
    tdd_sync_ext_edge   = '0;
    tdd_sync_int        = 1'b0;
    tdd_sync_soft       = 1'b0;
    tdd_sync_oneshot    = 1'b0;
    asy_tdd_sync_period = '0;
    asy_tdd_sync_width  = '0;
    modelReset();
    doReset();

    $display("[TB] reset mid-pulse, then soft strobe after release");
    st_width = 8'd6;
    st_en    = 1'b1;
    repeat (3) applyStimulus();
    st_soft = 1'b1;
    applyStimulus();
    st_soft = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("pulse_before_rst", 32'(sync_out), 32'd1);
    doReset();
    st_en = 1'b1;
    repeat (2) applyStimulus();
    st_soft = 1'b1;
    applyStimulus();
    st_soft = 1'b0;
    repeat (8) applyStimulus();
    st_en = 1'b0;
    repeat (2) applyStimulus();

    $display("[TB] internal period 10 width 3, then period 0");
    runSession(10, 3, 1'b1, 1'b0, 2'b00, 2'b00, 60, 0, 0, 0, -1);
    runSession(0, 3, 1'b1, 1'b0, 2'b00, 2'b00, 1000, 0, 0, 0, -1);

    $display("[TB] external inputs with mixed CDC and edge select");
    runSession(0, 2, 1'b0, 1'b0, 2'b11, 2'b10, 120, 0, 10, 0, -1);

    $display("[TB] width 5, soft then external rise during pulse");
    st_width = 8'd5;
    st_mask  = 2'b01;
    st_edge  = 2'b00;
    st_int   = 1'b0;
    st_sync  = '0;
    st_en    = 1'b0;
    repeat (2) applyStimulus();
    st_en = 1'b1;
    repeat (3) applyStimulus();
    st_soft = 1'b1;
    applyStimulus();
    st_soft    = 1'b0;
    st_sync[0] = 1'b1;
    applyStimulus();
    repeat (8) applyStimulus();
    st_en = 1'b0;
    repeat (2) applyStimulus();

    $display("[TB] one-shot sessions");
    runSession(4, 2, 1'b1, 1'b1, 2'b00, 2'b00, 40, 0, 0, 0, -1);
    runSession(4, 2, 1'b1, 1'b1, 2'b00, 2'b00, 40, 0, 0, 0, -1);

    $display("[TB] period change while enabled");
    runSession(8, 2, 1'b1, 1'b0, 2'b00, 2'b00, 60, 0, 0, 0, 3);
    runSession(3, 1, 1'b1, 1'b0, 2'b00, 2'b00, 30, 0, 0, 0, -1);

    $display("[TB] randomized sessions");
    for (int s = 0; s < 30; s++) begin
      runSession(int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                 bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 150, 5, 8, (($urandom_range(0, 1) == 0) ? 0 : 3),
                 ((s % 5) == 0) ? int'($urandom_range(1, 9)) : -1);
      if ((s % 10) == 9) doReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
